// File: rtl/fetch_stage_pc_predict.sv
// fetch_stage_pc_predict
// Instruction fetch stage. It holds the fetch PC and chooses the next PC from,
// in priority order: EX redirect, stall, halt, BTB prediction, and PC+2.
// The optional direct-mapped BTB uses 2-bit saturating counters. It is built
// only when the macro BTB_PREDICT_EN is defined. Without the macro the stage
// never predicts and ignores the upd_* inputs.
module fetch_stage_pc_predict #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        upd_en,
    input  logic [15:0] upd_pc,
    input  logic        upd_taken,
    input  logic [15:0] upd_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] IF_PC,
    output logic [15:0] IF_PCPlus2,
    output logic [15:0] IF_Instruction,
    output logic        IF_PredictedTaken,
    output logic        IF_Halted
);

    logic [15:0] pc_q;
    logic [15:0] pc_next;
    logic        halted_q;
    logic        halted_next;
    logic        hlt_seen;
    logic        predicted_taken;
    logic [15:0] pred_target;

`ifdef BTB_PREDICT_EN
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 15 - INDEX_BITS;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [15:0]      tgt_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]      u_tag;
    logic                  hit;

    assign idx   = pc_q[INDEX_BITS:1];
    assign tag   = pc_q[15:INDEX_BITS+1];
    assign u_idx = upd_pc[INDEX_BITS:1];
    assign u_tag = upd_pc[15:INDEX_BITS+1];

    // BTB lookup on the current fetch PC; the lookup sees contents from before this edge's write
    always_comb begin
        hit             = valid_q[idx] && (tag_q[idx] == tag);
        predicted_taken = hit && ctr_q[idx][1];
        pred_target     = tgt_q[idx];
    end

    // BTB training from resolved branches; a miss installs the entry, a hit nudges the counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_en) begin
            if (!valid_q[u_idx] || (tag_q[u_idx] != u_tag)) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                tgt_q[u_idx]   <= upd_target;
                ctr_q[u_idx]   <= upd_taken ? 2'b10 : 2'b01;
            end else if (upd_taken) begin
                tgt_q[u_idx] <= upd_target;
                if (ctr_q[u_idx] != 2'b11) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
                end
            end else if (ctr_q[u_idx] != 2'b00) begin
                ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
            end
        end
    end
`else
    logic unused_upd;

    assign unused_upd      = ^{upd_en, upd_pc, upd_taken, upd_target};
    assign predicted_taken = 1'b0;
    assign pred_target     = 16'h0000;
`endif

    assign hlt_seen = (imem_data[15:12] == 4'hF);

    // Next-PC selection: redirect beats stall, stall beats halt, halt beats prediction
    always_comb begin
        pc_next     = pc_q + 16'd2;
        halted_next = halted_q;
        if (redirect) begin
            pc_next     = redirect_pc;
            halted_next = 1'b0;
        end else if (stall) begin
            pc_next = pc_q;
        end else if (halted_q || hlt_seen) begin
            pc_next     = pc_q;
            halted_next = 1'b1;
        end else if (predicted_taken) begin
            pc_next = pred_target;
        end
    end

    // PC and halt flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_next;
            halted_q <= halted_next;
        end
    end

    assign imem_addr         = pc_q;
    assign IF_PC             = pc_q;
    assign IF_PCPlus2        = pc_q + 16'd2;
    assign IF_Instruction    = imem_data;
    assign IF_PredictedTaken = predicted_taken;
    assign IF_Halted         = halted_q;

endmodule

// File: tb/tb_fetch_stage_pc_predict.sv
// tb_fetch_stage_pc_predict
// Directed and random checks for the fetch stage. A behavioural model of the
// PC and BTB is written in plain integer arithmetic. Define BTB_PREDICT_EN to
// expect the predictor to be present.
module tb_fetch_stage_pc_predict;

`ifdef BTB_PREDICT_EN
    localparam bit PRED_ON = 1'b1;
`else
    localparam bit PRED_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] IF_PC;
    logic [15:0] IF_PCPlus2;
    logic [15:0] IF_Instruction;
    logic        IF_PredictedTaken;
    logic        IF_Halted;

    int checks = 0;
    int errors = 0;

    // Model state: 8 BTB entries, indexed by (pc/2) mod 8, with tag pc/16
    int m_pc;
    bit m_halted;
    bit m_valid [8];
    int m_tag   [8];
    int m_tgt   [8];
    int m_ctr   [8];

    fetch_stage_pc_predict #(.RESET_PC(16'h0000), .INDEX_BITS(3)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .upd_en(upd_en),
        .upd_pc(upd_pc),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .IF_PC(IF_PC),
        .IF_PCPlus2(IF_PCPlus2),
        .IF_Instruction(IF_Instruction),
        .IF_PredictedTaken(IF_PredictedTaken),
        .IF_Halted(IF_Halted)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc     = 0;
        m_halted = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
    endtask

    function automatic bit model_pred();
        int i;
        i = (m_pc / 2) % 8;
        return PRED_ON && m_valid[i] && (m_tag[i] == m_pc / 16) && (m_ctr[i] >= 2);
    endfunction

    task automatic model_step();
        bit pred;
        int i;
        pred = model_pred();
        i    = (m_pc / 2) % 8;
        if (redirect) begin
            m_pc     = int'(redirect_pc);
            m_halted = 1'b0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (m_halted || (int'(imem_data) / 4096 == 15)) begin
            m_halted = 1'b1;
        end else if (pred) begin
            m_pc = m_tgt[i];
        end else begin
            m_pc = (m_pc + 2) % 65536;
        end
        if (PRED_ON && upd_en) begin
            int u;
            int t;
            u = (int'(upd_pc) / 2) % 8;
            t = int'(upd_pc) / 16;
            if (!m_valid[u] || m_tag[u] != t) begin
                m_valid[u] = 1'b1;
                m_tag[u]   = t;
                m_tgt[u]   = int'(upd_target);
                m_ctr[u]   = upd_taken ? 2 : 1;
            end else if (upd_taken) begin
                m_tgt[u] = int'(upd_target);
                m_ctr[u] = (m_ctr[u] < 3) ? m_ctr[u] + 1 : 3;
            end else begin
                m_ctr[u] = (m_ctr[u] > 0) ? m_ctr[u] - 1 : 0;
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check_val("IF_PC", {16'h0, IF_PC}, m_pc);
        check_val("imem_addr", {16'h0, imem_addr}, m_pc);
        check_val("IF_PCPlus2", {16'h0, IF_PCPlus2}, (m_pc + 2) % 65536);
        check_val("IF_Instruction", {16'h0, IF_Instruction}, {16'h0, imem_data});
        check_val("IF_PredictedTaken", {31'h0, IF_PredictedTaken}, {31'h0, model_pred()});
        check_val("IF_Halted", {31'h0, IF_Halted}, {31'h0, m_halted});
    endtask

    // One cycle: drive inputs, check outputs on the falling edge, advance the model, return at posedge+1
    task automatic applyStimulus(input logic st, input logic rd, input logic [15:0] rdpc,
                                 input logic ue, input logic [15:0] upc, input logic ut,
                                 input logic [15:0] utgt, input logic [15:0] instr);
        stall       = st;
        redirect    = rd;
        redirect_pc = rdpc;
        upd_en      = ue;
        upd_pc      = upc;
        upd_taken   = ut;
        upd_target  = utgt;
        imem_data   = instr;
        @(negedge clk);
        checkOutput();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        imem_data = 16'h0000;
        model_reset();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Plain sequential fetch
        check_val("seq0", {16'h0, IF_PC}, 32'h0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h1234);
        check_val("seq2", {16'h0, IF_PC}, 32'h2);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0000);
        check_val("seq4", {16'h0, IF_PC}, 32'h4);

        // Asynchronous reset mid-run at pc 0x0040
        applyStimulus(0, 1, 16'h0040, 0, 16'h0, 0, 16'h0, 16'h0000);
        check_val("at_0040", {16'h0, IF_PC}, 32'h40);
        rst = 1'b1;
        #1;
        check_val("async_rst_pc", {16'h0, IF_PC}, 32'h0);
        check_val("async_rst_pred", {31'h0, IF_PredictedTaken}, 32'h0);
        model_reset();
        #2;
        rst = 1'b0;
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0000);
        check_val("rst_seq2", {16'h0, IF_PC}, 32'h2);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0000);
        check_val("rst_seq4", {16'h0, IF_PC}, 32'h4);

        // Install taken branch at 0x0010 -> 0x0100 while redirecting there
        applyStimulus(0, 1, 16'h0010, 1, 16'h0010, 1, 16'h0100, 16'h0000);
        check_val("pred_hit", {31'h0, IF_PredictedTaken}, {31'h0, PRED_ON});
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0000);
        check_val("pred_target", {16'h0, IF_PC}, PRED_ON ? 32'h0100 : 32'h0012);

        // Counter behaviour, parked at 0x0010 using stall
        applyStimulus(0, 1, 16'h0010, 0, 16'h0, 0, 16'h0, 16'h0000);
        applyStimulus(1, 0, 16'h0, 1, 16'h0010, 0, 16'h0100, 16'h0000);
        check_val("ctr_nt_01", {31'h0, IF_PredictedTaken}, 32'h0);
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 16'h0, 1, 16'h0010, 1, 16'h0100, 16'h0000);
        check_val("ctr_sat_hi", {31'h0, IF_PredictedTaken}, {31'h0, PRED_ON});
        applyStimulus(1, 0, 16'h0, 1, 16'h0010, 0, 16'h0100, 16'h0000);
        check_val("ctr_hi_minus1", {31'h0, IF_PredictedTaken}, {31'h0, PRED_ON});
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 16'h0, 1, 16'h0010, 0, 16'h0100, 16'h0000);
        check_val("ctr_sat_lo", {31'h0, IF_PredictedTaken}, 32'h0);
        applyStimulus(1, 0, 16'h0, 1, 16'h0010, 1, 16'h0100, 16'h0000);
        check_val("ctr_lo_plus1", {31'h0, IF_PredictedTaken}, 32'h0);
        applyStimulus(1, 0, 16'h0, 1, 16'h0010, 1, 16'h0100, 16'h0000);
        check_val("ctr_lo_plus2", {31'h0, IF_PredictedTaken}, {31'h0, PRED_ON});

        // Alias: 0x0020 shares the index and evicts 0x0010
        applyStimulus(1, 0, 16'h0, 1, 16'h0020, 1, 16'h0300, 16'h0000);
        check_val("alias_evict", {31'h0, IF_PredictedTaken}, 32'h0);

        // Redirect wins over stall
        applyStimulus(1, 1, 16'h0200, 0, 16'h0, 0, 16'h0, 16'h0000);
        check_val("prio_redirect", {16'h0, IF_PC}, 32'h0200);

        // Stall holds PC and PC+2 for three cycles
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0000);
            check_val("stall_pc", {16'h0, IF_PC}, 32'h0200);
            check_val("stall_pc2", {16'h0, IF_PCPlus2}, 32'h0202);
        end

        // Halt at 0x0008, then release with redirect to 0x0020
        applyStimulus(0, 1, 16'h0008, 0, 16'h0, 0, 16'h0, 16'h0000);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'hF000);
        check_val("halt_pc", {16'h0, IF_PC}, 32'h0008);
        check_val("halt_flag", {31'h0, IF_Halted}, 32'h1);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0000);
        check_val("halt_hold", {16'h0, IF_PC}, 32'h0008);
        applyStimulus(0, 1, 16'h0020, 0, 16'h0, 0, 16'h0, 16'h0000);
        check_val("halt_resume", {16'h0, IF_PC}, 32'h0020);
        check_val("halt_clear", {31'h0, IF_Halted}, 32'h0);

        // PC wrap
        applyStimulus(0, 1, 16'hFFFE, 0, 16'h0, 0, 16'h0, 16'h0000);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0000);
        check_val("wrap", {16'h0, IF_PC}, 32'h0000);

        // Random traffic in a small address window
        for (int n = 0; n < 300; n++) begin
            logic        st, rd, ue, ut;
            logic [15:0] rdpc, upc, utgt, instr;
            st    = ($urandom_range(0, 9) == 0);
            rd    = ($urandom_range(0, 7) == 0) || m_halted;
            rdpc  = 16'($urandom_range(0, 31) * 2);
            ue    = ($urandom_range(0, 2) == 0);
            upc   = 16'($urandom_range(0, 31) * 2);
            ut    = $urandom_range(0, 1) == 1;
            utgt  = 16'($urandom_range(0, 31) * 2);
            instr = ($urandom_range(0, 19) == 0) ? 16'hF000 : 16'($urandom_range(0, 16'hEFFF));
            if (m_halted && $urandom_range(0, 1) == 1) rd = 1'b0;
            applyStimulus(st, rd, rdpc, ue, upc, ut, utgt, instr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
